// File: rtl/mem_access.sv
// LC3 memory-access stage: runs LD/LDR/LDI/ST/STR/STI over a req/ack data-memory port.
// Optional MEM_TIMEOUT_EN adds a per-access ack timeout with a sticky mem_err flag.
module mem_access #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [15:0] NOP_IR  = 16'h5020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    input  logic [15:0] aluout_in,
    input  logic [1:0]  W_Control_in,
    input  logic [2:0]  dr_in,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic        dmem_rd,
    output logic        dmem_wr,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_dout,
    output logic        stall_mem,
    output logic        out_valid,
    output logic [15:0] memout,
    output logic [15:0] aluout_out,
    output logic [1:0]  W_Control_out,
    output logic [2:0]  dr_out,
    output logic [15:0] IR_Mem,
    output logic [15:0] Mem_Bypass_val,
    output logic        mem_err
);
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;

    typedef enum logic [2:0] {IDLE, RD_IND, RD, WR, DONE} state_t;

    state_t     state;
    logic [3:0] mem_op;
    logic       is_load;
    logic       timed_out;

    // The timeout compare below subtracts one from TIMEOUT.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mem_access: TIMEOUT must be at least 1");
    end

    assign mem_op         = IR_Mem[15:12];
    assign is_load        = (mem_op == OP_LD) || (mem_op == OP_LDR) || (mem_op == OP_LDI);
    assign Mem_Bypass_val = is_load ? memout : aluout_out;
    assign stall_mem      = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CNT_W-1:0] wait_cnt;
    logic             in_access;

    assign in_access = (state == RD_IND) || (state == RD) || (state == WR);
    assign timed_out = in_access && !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counts ack-less cycles; cleared on every ack so each access starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (!in_access || dmem_ack || timed_out) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timed_out) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dmem_addr     <= '0;
            dmem_din      <= '0;
            dmem_rd       <= 1'b0;
            dmem_wr       <= 1'b0;
            out_valid     <= 1'b0;
            memout        <= '0;
            aluout_out    <= '0;
            W_Control_out <= '0;
            dr_out        <= '0;
            IR_Mem        <= NOP_IR;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        IR_Mem        <= IR_Exec;
                        dmem_addr     <= M_Addr;
                        dmem_din      <= M_Data;
                        aluout_out    <= aluout_in;
                        W_Control_out <= W_Control_in;
                        dr_out        <= dr_in;
                        unique case (IR_Exec[15:12])
                            OP_LD, OP_LDR: begin
                                state   <= RD;
                                dmem_rd <= 1'b1;
                            end
                            OP_LDI, OP_STI: begin
                                state   <= RD_IND;
                                dmem_rd <= 1'b1;
                            end
                            OP_ST, OP_STR: begin
                                state   <= WR;
                                dmem_wr <= 1'b1;
                            end
                            default: begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                // Pointer fetch: the returned word becomes the real address.
                RD_IND: begin
                    if (dmem_ack) begin
                        dmem_addr <= dmem_dout;
                        if (mem_op == OP_STI) begin
                            state   <= WR;
                            dmem_rd <= 1'b0;
                            dmem_wr <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end else if (timed_out) begin
                        state     <= DONE;
                        dmem_rd   <= 1'b0;
                        memout    <= '0;
                        out_valid <= 1'b1;
                    end
                end
                RD: begin
                    if (dmem_ack) begin
                        state     <= DONE;
                        dmem_rd   <= 1'b0;
                        memout    <= dmem_dout;
                        out_valid <= 1'b1;
                    end else if (timed_out) begin
                        state     <= DONE;
                        dmem_rd   <= 1'b0;
                        memout    <= '0;
                        out_valid <= 1'b1;
                    end
                end
                WR: begin
                    if (dmem_ack) begin
                        state     <= DONE;
                        dmem_wr   <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (timed_out) begin
                        state     <= DONE;
                        dmem_wr   <= 1'b0;
                        memout    <= '0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    IR_Mem <= NOP_IR;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected results queued at issue, checked on out_valid.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] IR_Exec, M_Addr, M_Data, aluout_in;
    logic [1:0]  W_Control_in;
    logic [2:0]  dr_in;
    logic [15:0] dmem_addr, dmem_din, dmem_dout;
    logic        dmem_rd, dmem_wr, dmem_ack;
    logic        stall_mem, out_valid, mem_err;
    logic [15:0] memout, aluout_out, IR_Mem, Mem_Bypass_val;
    logic [1:0]  W_Control_out;
    logic [2:0]  dr_out;

    mem_access dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .IR_Exec(IR_Exec), .M_Addr(M_Addr),
        .M_Data(M_Data), .aluout_in(aluout_in), .W_Control_in(W_Control_in), .dr_in(dr_in),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_ack(dmem_ack), .dmem_dout(dmem_dout), .stall_mem(stall_mem), .out_valid(out_valid),
        .memout(memout), .aluout_out(aluout_out), .W_Control_out(W_Control_out), .dr_out(dr_out),
        .IR_Mem(IR_Mem), .Mem_Bypass_val(Mem_Bypass_val), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] mem;
        logic [15:0] alu;
        logic [15:0] ir;
        logic [15:0] byp;
        logic [1:0]  wc;
        logic [2:0]  dr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp, mon_got;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   overlap = 1'b0;
    logic [15:0] model_mem = 16'h0000;

    // Result monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dmem_rd && dmem_wr) overlap = 1'b1;
        if (out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out_valid: got strobe with IR_Mem=%h, required no strobe", IR_Mem);
            end else begin
                mon_exp = sb.pop_front();
                mon_got = '{mem: memout, alu: aluout_out, ir: IR_Mem, byp: Mem_Bypass_val,
                            wc: W_Control_out, dr: dr_out};
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL result: got mem=%h alu=%h ir=%h byp=%h wc=%b dr=%0d, required mem=%h alu=%h ir=%h byp=%h wc=%b dr=%0d",
                             mon_got.mem, mon_got.alu, mon_got.ir, mon_got.byp, mon_got.wc, mon_got.dr,
                             mon_exp.mem, mon_exp.alu, mon_exp.ir, mon_exp.byp, mon_exp.wc, mon_exp.dr);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [15:0] ir, input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] alu, input logic [1:0] wc, input logic [2:0] dr);
        valid_in = 1'b1; IR_Exec = ir; M_Addr = addr; M_Data = data;
        aluout_in = alu; W_Control_in = wc; dr_in = dr;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Memory responder: waits for a request, holds ack low for 'waits' cycles, then acks once.
    task automatic serve(input int waits, input logic [15:0] rdata, output logic [15:0] a,
                         output logic [15:0] d, output logic r, output logic w, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(dmem_rd || dmem_wr)) begin
            if (n++ > 50) begin ok = 1'b0; return; end
            @(negedge clk);
        end
        repeat (waits) @(negedge clk);
        a = dmem_addr; d = dmem_din; r = dmem_rd; w = dmem_wr;
        dmem_ack = 1'b1; dmem_dout = rdata;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_dout = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (IR_Mem !== 16'h5020) begin
            n_err++; $display("FAIL reset_ir: got %h, required 5020", IR_Mem);
        end
        n_cmp++;
        if ({dmem_rd, dmem_wr, out_valid, stall_mem, mem_err, W_Control_out, dr_out} !== 10'b0) begin
            n_err++; $display("FAIL reset_ctrl: got rd=%b wr=%b ov=%b st=%b err=%b wc=%b dr=%0d, required all 0",
                              dmem_rd, dmem_wr, out_valid, stall_mem, mem_err, W_Control_out, dr_out);
        end
        n_cmp++;
        if ({memout, aluout_out, dmem_addr, dmem_din, Mem_Bypass_val} !== 80'b0) begin
            n_err++; $display("FAIL reset_data: got mem=%h alu=%h addr=%h din=%h byp=%h, required all 0000",
                              memout, aluout_out, dmem_addr, dmem_din, Mem_Bypass_val);
        end
        rst = 1'b0;
        model_mem = 16'h0000;
    endtask

    task automatic test_ld();
        logic [15:0] a, d; logic r, w; bit ok;
        sb.push_back('{mem: 16'hBEEF, alu: 16'h1111, ir: 16'h2405, byp: 16'hBEEF, wc: 2'b01, dr: 3'd2});
        issue(16'h2405, 16'h3005, 16'h0000, 16'h1111, 2'b01, 3'd2);
        n_cmp++;
        if ({dmem_rd, dmem_wr, stall_mem, dmem_addr} !== {3'b101, 16'h3005}) begin
            n_err++; $display("FAIL ld_req: got rd=%b wr=%b st=%b addr=%h, required rd=1 wr=0 st=1 addr=3005",
                              dmem_rd, dmem_wr, stall_mem, dmem_addr);
        end
        serve(0, 16'hBEEF, a, d, r, w, ok);
        n_cmp++;
        if (!ok || out_valid !== 1'b1 || dmem_rd !== 1'b0) begin
            n_err++; $display("FAIL ld_latency: got ok=%b out_valid=%b rd=%b two cycles after issue, required 1 1 0",
                              ok, out_valid, dmem_rd);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, stall_mem} !== 2'b00) begin
            n_err++; $display("FAIL ld_after: got out_valid=%b stall=%b, required 0 0", out_valid, stall_mem);
        end
        model_mem = 16'hBEEF;
    endtask

    task automatic test_ldr_wait();
        logic [15:0] a, d; logic r, w; bit ok;
        sb.push_back('{mem: 16'h0F0F, alu: 16'h2222, ir: 16'h6A81, byp: 16'h0F0F, wc: 2'b10, dr: 3'd5});
        issue(16'h6A81, 16'h3100, 16'h0000, 16'h2222, 2'b10, 3'd5);
        serve(3, 16'h0F0F, a, d, r, w, ok);
        n_cmp++;
        if (!ok || a !== 16'h3100 || r !== 1'b1 || w !== 1'b0) begin
            n_err++; $display("FAIL ldr_hold: got ok=%b addr=%h rd=%b wr=%b at ack, required addr=3100 rd=1 wr=0",
                              ok, a, r, w);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL ldr_latency: got out_valid=%b, required 1", out_valid);
        end
        @(negedge clk);
        model_mem = 16'h0F0F;
    endtask

    task automatic test_ldi();
        logic [15:0] a, d; logic r, w; bit ok;
        sb.push_back('{mem: 16'h1234, alu: 16'h3333, ir: 16'hA600, byp: 16'h1234, wc: 2'b01, dr: 3'd3});
        issue(16'hA600, 16'h3000, 16'h0000, 16'h3333, 2'b01, 3'd3);
        serve(0, 16'h4010, a, d, r, w, ok);
        n_cmp++;
        if (!ok || a !== 16'h3000) begin
            n_err++; $display("FAIL ldi_ptr_addr: got ok=%b addr=%h, required addr=3000", ok, a);
        end
        n_cmp++;
        if ({dmem_rd, dmem_wr, stall_mem, out_valid, dmem_addr} !== {4'b1010, 16'h4010}) begin
            n_err++; $display("FAIL ldi_second_req: got rd=%b wr=%b st=%b ov=%b addr=%h, required 1 0 1 0 addr=4010",
                              dmem_rd, dmem_wr, stall_mem, out_valid, dmem_addr);
        end
        serve(1, 16'h1234, a, d, r, w, ok);
        n_cmp++;
        if (!ok || out_valid !== 1'b1 || stall_mem !== 1'b1) begin
            n_err++; $display("FAIL ldi_done: got ok=%b out_valid=%b stall=%b, required 1 1", ok, out_valid, stall_mem);
        end
        @(negedge clk);
        n_cmp++;
        if (stall_mem !== 1'b0) begin
            n_err++; $display("FAIL ldi_release: got stall=%b after DONE, required 0", stall_mem);
        end
        model_mem = 16'h1234;
    endtask

    task automatic test_sti();
        logic [15:0] a, d; logic r, w; bit ok;
        sb.push_back('{mem: model_mem, alu: 16'h0055, ir: 16'hB802, byp: 16'h0055, wc: 2'b00, dr: 3'd4});
        issue(16'hB802, 16'h3002, 16'h00AA, 16'h0055, 2'b00, 3'd4);
        serve(0, 16'h5000, a, d, r, w, ok);
        serve(2, 16'h0000, a, d, r, w, ok);
        n_cmp++;
        if (!ok || a !== 16'h5000 || d !== 16'h00AA || w !== 1'b1 || r !== 1'b0) begin
            n_err++; $display("FAIL sti_write: got ok=%b addr=%h din=%h wr=%b rd=%b, required addr=5000 din=00AA wr=1 rd=0",
                              ok, a, d, w, r);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL sti_done: got out_valid=%b, required 1", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (overlap !== 1'b0) begin
            n_err++; $display("FAIL rd_wr_overlap: got rd and wr high together, required never");
        end
    endtask

    task automatic test_alu_op();
        sb.push_back('{mem: model_mem, alu: 16'h0007, ir: 16'h1262, byp: 16'h0007, wc: 2'b10, dr: 3'd1});
        issue(16'h1262, 16'h7777, 16'h8888, 16'h0007, 2'b10, 3'd1);
        n_cmp++;
        if ({out_valid, stall_mem, dmem_rd, dmem_wr} !== 4'b1100) begin
            n_err++; $display("FAIL alu_done: got ov=%b st=%b rd=%b wr=%b, required 1 1 0 0",
                              out_valid, stall_mem, dmem_rd, dmem_wr);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, stall_mem} !== 2'b00) begin
            n_err++; $display("FAIL alu_stall_len: got ov=%b st=%b, required 0 0", out_valid, stall_mem);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, d; logic r, w; bit ok;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_cmp++;
        if ({dmem_rd, dmem_wr, stall_mem, out_valid} !== 4'b0000) begin
            n_err++; $display("FAIL idle_ack: got rd=%b wr=%b st=%b ov=%b, required all 0",
                              dmem_rd, dmem_wr, stall_mem, out_valid);
        end
        sb.push_back('{mem: model_mem, alu: 16'h0042, ir: 16'h1021, byp: 16'h0042, wc: 2'b10, dr: 3'd0});
        issue(16'h1021, 16'h0000, 16'h0000, 16'h0042, 2'b10, 3'd0);
        @(negedge clk);
        sb.push_back('{mem: 16'hCAFE, alu: 16'h0000, ir: 16'h2E10, byp: 16'hCAFE, wc: 2'b01, dr: 3'd7});
        issue(16'h2E10, 16'h3200, 16'h0000, 16'h0000, 2'b01, 3'd7);
        n_cmp++;
        if ({dmem_rd, dmem_addr} !== {1'b1, 16'h3200}) begin
            n_err++; $display("FAIL b2b_accept: got rd=%b addr=%h, required rd=1 addr=3200", dmem_rd, dmem_addr);
        end
        serve(0, 16'hCAFE, a, d, r, w, ok);
        @(negedge clk);
        model_mem = 16'hCAFE;
    endtask

    task automatic test_reset_mid();
        issue(16'h2A00, 16'h3300, 16'h0000, 16'h0009, 2'b01, 3'd5);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_rd, out_valid, stall_mem, IR_Mem} !== {3'b000, 16'h5020}) begin
            n_err++; $display("FAIL reset_mid: got rd=%b ov=%b st=%b ir=%h, required 0 0 0 ir=5020",
                              dmem_rd, out_valid, stall_mem, IR_Mem);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, memout} !== 17'b0) begin
            n_err++; $display("FAIL reset_mid_after: got ov=%b mem=%h, required 0 0000", out_valid, memout);
        end
        model_mem = 16'h0000;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        sb.push_back('{mem: 16'h0000, alu: 16'h0101, ir: 16'h2200, byp: 16'h0000, wc: 2'b01, dr: 3'd1});
        issue(16'h2200, 16'h3400, 16'h0000, 16'h0101, 2'b01, 3'd1);
        while (dmem_rd && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt !== 15 || out_valid !== 1'b1 || mem_err !== 1'b1) begin
            n_err++; $display("FAIL timeout: got rd_cycles=%0d ov=%b err=%b, required 15 1 1", cnt, out_valid, mem_err);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_err !== 1'b1) begin
            n_err++; $display("FAIL timeout_sticky: got err=%b, required 1", mem_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (mem_err !== 1'b0) begin
            n_err++; $display("FAIL timeout_clear: got err=%b after rst, required 0", mem_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; valid_in = 1'b0; IR_Exec = '0; M_Addr = '0; M_Data = '0;
        aluout_in = '0; W_Control_in = '0; dr_in = '0; dmem_ack = 1'b0; dmem_dout = '0;
        test_reset();
        test_ld();
        test_ldr_wait();
        test_ldi();
        test_sti();
        test_alu_op();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- LC3 pipeline memory-access stage, directly downstream of the execute stage.
- Consumes execute's registered results: computed address (pcout), store data (M_Data), ALU result, W_Control and IR_Exec.
- Runs a multi-cycle data-memory transaction over a req/ack interface, including the two-access indirect ops LDI and STI.
- Stalls the pipeline while busy, then hands one result beat to writeback and the bypass network.

Parameters:
- TIMEOUT, 15: max cycles to wait for dmem_ack per access; used only when MEM_TIMEOUT_EN is defined.
- NOP_IR, 16'h5020: IR value reported when idle or after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  execute has a new instruction this cycle
- IR_Exec  in  16  instruction from execute
- M_Addr  in  16  effective address (execute pcout)
- M_Data  in  16  store data
- aluout_in  in  16  ALU result
- W_Control_in  in  2  writeback select, passed through
- dr_in  in  3  destination register, passed through
- dmem_addr  out  16  data memory address
- dmem_din  out  16  data memory write data
- dmem_rd  out  1  read request
- dmem_wr  out  1  write request
- dmem_ack  in  1  memory completes the current request this cycle
- dmem_dout  in  16  read data, valid in the ack cycle
- stall_mem  out  1  stage busy; upstream holds
- out_valid  out  1  one-cycle result strobe
- memout  out  16  loaded data
- aluout_out  out  16  registered ALU result
- W_Control_out  out  2  registered writeback control
- dr_out  out  3  registered destination register
- IR_Mem  out  16  instruction in this stage
- Mem_Bypass_val  out  16  memout for loads, else aluout_out
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset: all outputs 0 except IR_Mem = NOP_IR; state IDLE.
- Reset has priority in every state, including mid-transaction. Requests drop the next cycle and no out_valid is issued.
- States: IDLE, RD_IND, RD, WR, DONE.
- stall_mem = (state != IDLE), decoded from the state register.
- valid_in is sampled only in IDLE. In that cycle, latch IR, addr, data, aluout, W_Control and dr. Decode opcode IR[15:12]:
  - LD 0010, LDR 0110: go to RD; addr = M_Addr.
  - LDI 1010, STI 1011: go to RD_IND; addr = M_Addr.
  - ST 0011, STR 0111: go to WR; addr = M_Addr, din = M_Data.
  - Any other opcode: go to DONE; no memory request.
- RD_IND: assert dmem_rd.
  - On ack, load the latched address with dmem_dout.
  - LDI continues to RD; STI continues to WR.
- RD: assert dmem_rd. On ack, memout <= dmem_dout and go to DONE.
- WR: assert dmem_wr with din. On ack, go to DONE. memout is unchanged.
- Request rules:
  - dmem_rd/dmem_wr are registered and asserted from the first cycle of the state.
  - Address, data and request stay stable until ack is sampled high.
  - Requests deassert in the cycle after ack.
  - dmem_rd and dmem_wr are never high together.
  - Ack while no request is outstanding is ignored.
- DONE: out_valid = 1 for exactly one cycle, outputs valid, then return to IDLE.
- Latency from the valid_in cycle to out_valid:
  - Non-memory op: 1 cycle.
  - Single access: 2 + ack wait.
  - Indirect op: 3 + both ack waits.
- Back-to-back: the next valid_in can be accepted in the IDLE cycle after DONE.
- Mem_Bypass_val: memout when IR_Mem is LD/LDR/LDI, else aluout_out.

Optional Feature:
- Macro MEM_TIMEOUT_EN. When defined:
  - A 4-bit+ counter resets on entry to each access state and increments each cycle without ack.
  - When the count reaches TIMEOUT: drop the request, set mem_err (cleared only by rst), go to DONE with memout = 16'h0000.
- When not defined: the FSM waits indefinitely for ack, and mem_err is tied 0.

Test Plan:
- LD, M_Addr = 16'h3005, ack 1 cycle after rd with dout = 16'hBEEF -> dmem_rd for 1 cycle; out_valid 2 cycles after valid_in; memout = BEEF; Mem_Bypass_val = BEEF.
- LDI, M_Addr = 16'h3000; first read returns 16'h4010, second returns 16'h1234 -> second request addr = 4010; memout = 1234; stall_mem high until DONE.
- STI, M_Addr = 16'h3002, M_Data = 16'h00AA, pointer read returns 16'h5000 -> dmem_wr with addr 5000, din 00AA; dmem_rd never high together with dmem_wr.
- ADD (IR = 16'h1262), aluout_in = 16'h0007 -> no dmem request; out_valid 1 cycle later; Mem_Bypass_val = 0007; stall_mem high exactly 1 cycle.
- rst asserted while in RD with ack held low -> next cycle: dmem_rd = 0, IR_Mem = 5020, no out_valid, stall_mem = 0.
- With MEM_TIMEOUT_EN, TIMEOUT = 15, ack never asserted on an LD -> at the 15th wait cycle the request drops, mem_err = 1, out_valid with memout = 0000; mem_err persists until rst.
